trace_fabric_demux: RTL

//   Packet-level demultiplexer for the trace fabric: splits one channel-tagged Avalon-ST byte stream

---
 rtl/trace_fabric_pkg.sv | 19 +
 rtl/trace_fabric_demux_out_stage.sv | 52 +++++
 rtl/trace_fabric_demux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/trace_fabric_pkg.sv
// Shared types and constants for the trace fabric demultiplexer.
package trace_fabric_pkg;

   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_CHANNEL_WIDTH = 2;
   localparam int ERR_CNT_W         = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } demux_state_t;

   // Select-field width; a single output still needs one select bit.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/trace_fabric_demux_out_stage.sv
// One-beat registered output buffer for one demux destination.
module trace_fabric_demux_out_stage #(
   parameter int DATA_WIDTH   = 8,
   parameter int OUT_CH_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [OUT_CH_WIDTH-1:0] src_channel,
   input  logic [DATA_WIDTH-1:0]   src_data,
   input  logic                    src_sop,
   input  logic                    src_eop,
   input  logic                    ready,
   output logic                    valid,
   output logic [OUT_CH_WIDTH-1:0] channel,
   output logic [DATA_WIDTH-1:0]   data,
   output logic                    sop,
   output logic                    eop
);

   logic                    vld_p1;
   logic [OUT_CH_WIDTH-1:0] channel_p1;
   logic [DATA_WIDTH-1:0]   data_p1;
   logic                    sop_p1;
   logic                    eop_p1;

   // Stage p1: load wins over unload so a full buffer can refill in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1     <= 1'b0;
         channel_p1 <= '0;
         data_p1    <= '0;
         sop_p1     <= 1'b0;
         eop_p1     <= 1'b0;
      end else if (load) begin
         vld_p1     <= 1'b1;
         channel_p1 <= src_channel;
         data_p1    <= src_data;
         sop_p1     <= src_sop;
         eop_p1     <= src_eop;
      end else if (ready) begin
         vld_p1     <= 1'b0;
      end
   end

   assign valid   = vld_p1;
   assign channel = channel_p1;
   assign data    = data_p1;
   assign sop     = sop_p1;
   assign eop     = eop_p1;

endmodule

// File: rtl/trace_fabric_demux.sv
// Packet-locked channel demultiplexer for the trace fabric receive side.
// Optional framing-error counter enabled by TRACE_FABRIC_DEMUX_ERR_CNT_EN.
module trace_fabric_demux
   import trace_fabric_pkg::*;
#(
   parameter int NUM_OUTPUTS   = 2,
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
   localparam int SEL_W        = sel_w(NUM_OUTPUTS),
   localparam int OUT_CH_WIDTH = CHANNEL_WIDTH - SEL_W
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [CHANNEL_WIDTH-1:0]            in_channel,
   input  logic [DATA_WIDTH-1:0]               in_data,
   input  logic                                in_startofpacket,
   input  logic                                in_endofpacket,
   output logic [NUM_OUTPUTS-1:0]              out_valid,
   input  logic [NUM_OUTPUTS-1:0]              out_ready,
   output logic [NUM_OUTPUTS*OUT_CH_WIDTH-1:0] out_channel,
   output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]   out_data,
   output logic [NUM_OUTPUTS-1:0]              out_startofpacket,
   output logic [NUM_OUTPUTS-1:0]              out_endofpacket,
   output logic [ERR_CNT_W-1:0]                err_count
);

   demux_state_t         state, state_nxt;
   logic [SEL_W-1:0]     locked_sel;
   logic [SEL_W-1:0]     route_sel;
   logic                 route_drop;
   logic                 fwd_ready;
   logic [NUM_OUTPUTS-1:0] hit_vec;
   logic [NUM_OUTPUTS-1:0] load_vec;
   logic                 accept;

   // Stage p0: select decode; an out-of-range select means the packet is dropped.
   always_comb begin
      route_sel  = (state == IDLE || in_startofpacket) ?
                   in_channel[CHANNEL_WIDTH-1 -: SEL_W] : locked_sel;
      route_drop = 1'b1;
      fwd_ready  = 1'b0;
      hit_vec    = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         if (route_sel == SEL_W'(i)) begin
            route_drop = 1'b0;
            fwd_ready  = out_ready[i] | ~out_valid[i];
            hit_vec[i] = 1'b1;
         end
      end
      in_ready = route_drop | fwd_ready;
   end

   assign accept   = in_valid & in_ready;
   assign load_vec = accept ? hit_vec : '0;

   always_comb begin
      state_nxt = state;
      if (accept) begin
         if (in_endofpacket)  state_nxt = IDLE;
         else if (route_drop) state_nxt = DROP;
         else                 state_nxt = FWD;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         locked_sel <= '0;
      end else begin
         state <= state_nxt;
         if (accept) locked_sel <= route_sel;
      end
   end

   generate
      for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_out
         trace_fabric_demux_out_stage #(
            .DATA_WIDTH   (DATA_WIDTH),
            .OUT_CH_WIDTH (OUT_CH_WIDTH)
         ) u_stage (
            .clk         (clk),
            .reset_n     (reset_n),
            .load        (load_vec[g]),
            .src_channel (in_channel[OUT_CH_WIDTH-1:0]),
            .src_data    (in_data),
            .src_sop     (in_startofpacket),
            .src_eop     (in_endofpacket),
            .ready       (out_ready[g]),
            .valid       (out_valid[g]),
            .channel     (out_channel[g*OUT_CH_WIDTH +: OUT_CH_WIDTH]),
            .data        (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .sop         (out_startofpacket[g]),
            .eop         (out_endofpacket[g])
         );
      end
   endgenerate

`ifdef TRACE_FABRIC_DEMUX_ERR_CNT_EN
   logic                 frame_err;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Missing SOP at packet start, or a new SOP truncating the packet in flight.
   assign frame_err = accept & (((state == IDLE) & ~in_startofpacket) |
                                ((state != IDLE) &  in_startofpacket));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       err_cnt_q <= '0;
      else if (frame_err) err_cnt_q <= sat_inc(err_cnt_q);
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule
